hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage core: per-port E-stage bypass select (NUM_RPORTS ports),

---
 rtl/hazard_pkg.sv | 10 +
 rtl/md_scoreboard.sv | 49 ++++
 rtl/hazard_ctrl.sv | 100 ++++++++++
 tb/tb_hazard_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard controller and the E-stage operand bypass muxes.
package hazard_pkg;

    typedef enum logic [1:0] {
        FORWARD_N = 2'b00,
        FORWARD_W = 2'b01,
        FORWARD_M = 2'b10
    } forward_e;

endpackage

// File: rtl/md_scoreboard.sv
// Tracks the single in-flight MUL/DIV op: latency countdown, pending destination, commit pulse.
module md_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_SIZE   = 5,
    parameter int unsigned MD_LATENCY = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    input  logic [REG_SIZE-1:0] i_dest,
    output logic                o_busy,
    output logic                o_commit,
    output logic [REG_SIZE-1:0] o_reg
);

    localparam int unsigned CW = $clog2(MD_LATENCY + 1);

    logic                r_busy;
    logic [CW-1:0]       r_cnt;
    logic [REG_SIZE-1:0] r_reg;
    logic                w_commit;

    assign w_commit = r_busy && (r_cnt == CW'(1));

    // A start while busy is dropped: only one unit, and its result port is already claimed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_reg  <= '0;
        end else if (r_busy) begin
            r_cnt <= r_cnt - CW'(1);
            if (w_commit) begin
                r_busy <= 1'b0;
                r_reg  <= '0;
            end
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= CW'(MD_LATENCY);
            r_reg  <= i_dest;
        end
    end

    assign o_busy   = r_busy;
    assign o_commit = w_commit;
    assign o_reg    = r_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard control: E-stage bypass selects, load-use / MUL-DIV stalls, branch flush.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_SIZE   = 5,
    parameter int unsigned NUM_RPORTS = 2,
    parameter int unsigned MD_LATENCY = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_RPORTS*REG_SIZE-1:0] raddrD,
    input  logic [REG_SIZE-1:0]            writeRegD,
    input  logic                           regWriteD,
    input  logic                           mdD,
    input  logic [NUM_RPORTS*REG_SIZE-1:0] raddrE,
    input  logic [REG_SIZE-1:0]            writeRegE,
    input  logic                           regWriteE,
    input  logic                           memToRegE,
    input  logic                           pcSrcE,
    input  logic                           mdStartE,
    input  logic [REG_SIZE-1:0]            writeRegM,
    input  logic [REG_SIZE-1:0]            writeRegW,
    input  logic                           regWriteM,
    input  logic                           regWriteW,
    output logic [2*NUM_RPORTS-1:0]        forward,
    output logic                           stallF,
    output logic                           stallD,
    output logic                           flushD,
    output logic                           flushE,
    output logic                           mdBusy,
    output logic                           mdCommit,
    output logic [REG_SIZE-1:0]            mdReg
);

    logic [NUM_RPORTS-1:0] w_lw_hit;
    logic [NUM_RPORTS-1:0] w_md_raw;
    logic                  w_lw_stall;
    logic                  w_md_stall;
    logic                  w_stall;

    md_scoreboard #(
        .REG_SIZE   (REG_SIZE),
        .MD_LATENCY (MD_LATENCY)
    ) u_md_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .i_start  (mdStartE),
        .i_dest   (writeRegE),
        .o_busy   (mdBusy),
        .o_commit (mdCommit),
        .o_reg    (mdReg)
    );

    for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_port
        logic [REG_SIZE-1:0] w_ra_e;
        logic [REG_SIZE-1:0] w_ra_d;
        forward_e            w_sel;

        assign w_ra_e = raddrE[p*REG_SIZE +: REG_SIZE];
        assign w_ra_d = raddrD[p*REG_SIZE +: REG_SIZE];

        // r0 is hardwired zero, so it is never bypassed; M is the younger value and wins.
        always_comb begin
            w_sel = FORWARD_N;
            if (w_ra_e != '0 && w_ra_e == writeRegM && regWriteM) begin
                w_sel = FORWARD_M;
            end else if (w_ra_e != '0 && w_ra_e == writeRegW && regWriteW) begin
                w_sel = FORWARD_W;
            end
        end

        assign forward[2*p +: 2] = w_sel;
        assign w_lw_hit[p]       = (w_ra_d == writeRegE);
        assign w_md_raw[p]       = (w_ra_d == mdReg);
    end

    assign w_lw_stall = memToRegE && regWriteE && (writeRegE != '0) && (|w_lw_hit);

    // Pending reg stays blocked through the commit cycle; the regfile is written at that edge.
    assign w_md_stall = mdBusy && (mdD || ((mdReg != '0) &&
                        ((|w_md_raw) || (regWriteD && writeRegD == mdReg))));

    assign w_stall = w_lw_stall || w_md_stall;

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        if (pcSrcE) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (w_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: stimulus queues expectations, a monitor checks them.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] raddrD, raddrE;
    logic [4:0] writeRegD, writeRegE, writeRegM, writeRegW;
    logic       regWriteD, mdD, regWriteE, memToRegE, pcSrcE, mdStartE, regWriteM, regWriteW;
    logic [3:0] forward;
    logic       stallF, stallD, flushD, flushE, mdBusy, mdCommit;
    logic [4:0] mdReg;

    typedef struct {
        string      nm;
        logic [14:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // {stallF, stallD, flushD, flushE}
    localparam logic [3:0] NONE  = 4'b0000;
    localparam logic [3:0] STALL = 4'b1101;
    localparam logic [3:0] BR    = 4'b0011;

    hazard_ctrl #(
        .REG_SIZE   (5),
        .NUM_RPORTS (2),
        .MD_LATENCY (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .raddrD    (raddrD),
        .writeRegD (writeRegD),
        .regWriteD (regWriteD),
        .mdD       (mdD),
        .raddrE    (raddrE),
        .writeRegE (writeRegE),
        .regWriteE (regWriteE),
        .memToRegE (memToRegE),
        .pcSrcE    (pcSrcE),
        .mdStartE  (mdStartE),
        .writeRegM (writeRegM),
        .writeRegW (writeRegW),
        .regWriteM (regWriteM),
        .regWriteW (regWriteW),
        .forward   (forward),
        .stallF    (stallF),
        .stallD    (stallD),
        .flushD    (flushD),
        .flushE    (flushE),
        .mdBusy    (mdBusy),
        .mdCommit  (mdCommit),
        .mdReg     (mdReg)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] ex(input logic [3:0] f, input logic [3:0] ctl,
                                       input logic b, input logic c, input logic [4:0] r);
        return {f, ctl, b, c, r};
    endfunction

    task automatic clr();
        raddrD = '0; raddrE = '0;
        writeRegD = '0; writeRegE = '0; writeRegM = '0; writeRegW = '0;
        regWriteD = 0; mdD = 0; regWriteE = 0; memToRegE = 0; pcSrcE = 0; mdStartE = 0;
        regWriteM = 0; regWriteW = 0;
    endtask

    // Queue the expectation for the current cycle, then advance to just after the next edge.
    task automatic cyc(input string nm, input logic [14:0] v);
        exp_q.push_back('{nm, v});
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t        e;
        logic [14:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {forward, stallF, stallD, flushD, flushE, mdBusy, mdCommit, mdReg};
                checks++;
                if (act !== e.v) begin
                    failures++;
                    $display("FAIL %s: got fwd=%b sF/sD/fD/fE=%b busy=%b commit=%b reg=%0d, want fwd=%b sF/sD/fD/fE=%b busy=%b commit=%b reg=%0d",
                             e.nm, act[14:11], act[10:7], act[6], act[5], act[4:0],
                             e.v[14:11], e.v[10:7], e.v[6], e.v[5], e.v[4:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset = 1'b1;
        clr();
        @(posedge clk);
        #1;
        cyc("reset", ex(4'b0000, NONE, 0, 0, 5'd0));
        reset = 1'b0;

        // Bypass selection
        raddrE = {5'd0, 5'd3}; writeRegM = 5'd3; regWriteM = 1; writeRegW = 5'd3; regWriteW = 1;
        cyc("fwd_m_prio", ex(4'b0010, NONE, 0, 0, 5'd0));
        writeRegM = 5'd0;
        cyc("fwd_w_r0n", ex(4'b0001, NONE, 0, 0, 5'd0));
        raddrE = {5'd4, 5'd3}; writeRegM = 5'd4; writeRegW = 5'd4;
        cyc("fwd_mixed", ex(4'b1000, NONE, 0, 0, 5'd0));
        raddrE = {5'd6, 5'd6}; writeRegM = 5'd6; regWriteM = 0; writeRegW = 5'd6;
        cyc("fwd_m_nowe", ex(4'b0101, NONE, 0, 0, 5'd0));

        // Load-use stall, then forward from W two cycles on
        clr(); memToRegE = 1; regWriteE = 1; writeRegE = 5'd5; raddrD = {5'd5, 5'd1};
        cyc("lw_stall", ex(4'b0000, STALL, 0, 0, 5'd0));
        clr(); writeRegM = 5'd5; regWriteM = 1; raddrD = {5'd5, 5'd1};
        cyc("lw_bubble", ex(4'b0000, NONE, 0, 0, 5'd0));
        clr(); raddrE = {5'd5, 5'd1}; writeRegW = 5'd5; regWriteW = 1;
        cyc("lw_fwd_w", ex(4'b0100, NONE, 0, 0, 5'd0));
        clr(); memToRegE = 1; regWriteE = 1; writeRegE = 5'd0;
        cyc("lw_r0", ex(4'b0000, NONE, 0, 0, 5'd0));
        clr(); memToRegE = 1; writeRegE = 5'd5; raddrD = {5'd5, 5'd5};
        cyc("lw_nowe", ex(4'b0000, NONE, 0, 0, 5'd0));

        // Branch beats stall
        clr(); memToRegE = 1; regWriteE = 1; writeRegE = 5'd5; raddrD = {5'd1, 5'd5}; pcSrcE = 1;
        cyc("br_wins", ex(4'b0000, BR, 0, 0, 5'd0));

        // MUL/DIV RAW: issue r7 at cycle 0, busy 1-4, commit at 4
        clr(); mdStartE = 1; writeRegE = 5'd7; regWriteE = 1;
        cyc("md_issue", ex(4'b0000, NONE, 0, 0, 5'd0));
        clr(); raddrD = {5'd0, 5'd7};
        for (int i = 1; i <= 4; i++) cyc("md_raw", ex(4'b0000, STALL, 1, i == 4, 5'd7));
        cyc("md_raw_release", ex(4'b0000, NONE, 0, 0, 5'd0));

        // Second mdD waits out the busy window; illegal restart at cycle 2 is ignored
        clr(); mdStartE = 1; writeRegE = 5'd9; regWriteE = 1;
        cyc("md2_issue", ex(4'b0000, NONE, 0, 0, 5'd0));
        clr(); mdD = 1;
        cyc("md2_mdd", ex(4'b0000, STALL, 1, 0, 5'd9));
        mdStartE = 1; writeRegE = 5'd10; regWriteE = 1;
        cyc("md2_illegal", ex(4'b0000, STALL, 1, 0, 5'd9));
        mdStartE = 0; writeRegE = 5'd0; regWriteE = 0;
        cyc("md2_mdd", ex(4'b0000, STALL, 1, 0, 5'd9));
        cyc("md2_commit", ex(4'b0000, STALL, 1, 1, 5'd9));
        cyc("md2_release", ex(4'b0000, NONE, 0, 0, 5'd0));

        // WAW against pending r7
        clr(); mdStartE = 1; writeRegE = 5'd7; regWriteE = 1;
        cyc("waw_issue", ex(4'b0000, NONE, 0, 0, 5'd0));
        clr(); regWriteD = 1; writeRegD = 5'd7; raddrD = {5'd1, 5'd2};
        cyc("waw_stall", ex(4'b0000, STALL, 1, 0, 5'd7));
        writeRegD = 5'd8;
        cyc("waw_other", ex(4'b0000, NONE, 1, 0, 5'd7));
        clr();
        cyc("waw_idle", ex(4'b0000, NONE, 1, 0, 5'd7));
        cyc("waw_commit", ex(4'b0000, NONE, 1, 1, 5'd7));
        cyc("waw_done", ex(4'b0000, NONE, 0, 0, 5'd0));

        // Destination r0: runs normally, never blocks
        clr(); mdStartE = 1; writeRegE = 5'd0;
        cyc("r0_issue", ex(4'b0000, NONE, 0, 0, 5'd0));
        clr(); regWriteD = 1; writeRegD = 5'd0;
        for (int i = 1; i <= 4; i++) cyc("r0_busy", ex(4'b0000, NONE, 1, i == 4, 5'd0));

        // Reset mid-operation abandons the op
        clr(); mdStartE = 1; writeRegE = 5'd7; regWriteE = 1;
        cyc("rst_issue", ex(4'b0000, NONE, 0, 0, 5'd0));
        clr(); raddrD = {5'd0, 5'd7};
        cyc("rst_pre", ex(4'b0000, STALL, 1, 0, 5'd7));
        reset = 1'b1;
        cyc("rst_mid", ex(4'b0000, NONE, 0, 0, 5'd0));
        reset = 1'b0;
        for (int i = 3; i <= 5; i++) cyc("rst_after", ex(4'b0000, NONE, 0, 0, 5'd0));

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
